// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter folding NUM_PORTS request ports onto
// one downstream memory port. The arbiter holds its choice while a request
// stalls. A small ID FIFO routes the in-order responses back to their ports.
module mem_port_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_PORTS-1:0]                port_req_i,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     port_addr_i,
   input  logic [NUM_PORTS-1:0]                port_we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   port_be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_wdata_i,
   output logic [NUM_PORTS-1:0]                port_gnt_o,
   output logic [NUM_PORTS-1:0]                port_rvalid_o,
   output logic [DATA_WIDTH-1:0]               port_rdata_o,
   output logic                                mem_req_o,
   output logic [ADDR_WIDTH-1:0]               mem_addr_o,
   output logic                                mem_we_o,
   output logic [DATA_WIDTH/8-1:0]             mem_be_o,
   output logic [DATA_WIDTH-1:0]               mem_wdata_o,
   input  logic                                mem_gnt_i,
   input  logic                                mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
   output logic                                resp_err_o
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int FW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_arr;
   logic [NUM_PORTS-1:0][BE_W-1:0]       be_arr;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_arr;

   assign addr_arr  = port_addr_i;
   assign be_arr    = port_be_i;
   assign wdata_arr = port_wdata_i;

   logic [0:0]    state;
   logic [PW-1:0] rr_ptr, lock_idx, rr_sel, rr_cand, sel;
   logic          rr_hit;
   logic [CW-1:0] count;
   logic [FW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] id_fifo [MAX_OUTSTANDING];
   logic          push, pop, empty_rsp;

   // Round-robin search starting at rr_ptr; the first requester wins
   always_comb begin
      rr_sel  = rr_ptr;
      rr_cand = rr_ptr;
      rr_hit  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rr_cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
         if (!rr_hit && port_req_i[rr_cand]) begin
            rr_hit = 1'b1;
            rr_sel = rr_cand;
         end
      end
   end

   // While a request is stalled, keep presenting the locked port
   assign sel = (state == ST_LOCKED) ? lock_idx : rr_sel;

   // A full FIFO blocks new requests even when a pop happens in the same cycle
   assign mem_req_o = port_req_i[sel] & (count < CW'(MAX_OUTSTANDING)) & ~rst_i;
   assign push      = mem_req_o & mem_gnt_i;
   assign pop       = mem_rvalid_i & (count != '0) & ~rst_i;
   assign empty_rsp = mem_rvalid_i & (count == '0);

   // Downstream mux; the bus is zero whenever no request is presented
   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (mem_req_o) begin
         mem_addr_o  = addr_arr[sel];
         mem_we_o    = port_we_i[sel];
         mem_be_o    = be_arr[sel];
         mem_wdata_o = wdata_arr[sel];
      end
   end

   // Zero-latency grant and response steering
   always_comb begin
      port_gnt_o    = '0;
      port_rvalid_o = '0;
      if (push) port_gnt_o[sel] = 1'b1;
      if (pop)  port_rvalid_o[id_fifo[rd_ptr]] = 1'b1;
   end

   assign port_rdata_o = mem_rdata_i;

   // Lock FSM: latch the chosen port when the request stalls, release on grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         lock_idx <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (mem_req_o && !mem_gnt_i) begin
                  state    <= ST_LOCKED;
                  lock_idx <= sel;
               end
            default:
               if (mem_gnt_i) state <= ST_IDLE;
         endcase
      end
   end

   // Advance the round-robin pointer past the port that just transferred
   always_ff @(posedge clk_i) begin
      if (rst_i)     rr_ptr <= '0;
      else if (push) rr_ptr <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
   end

   // ID FIFO storage; contents are valid only below count, so no reset needed
   always_ff @(posedge clk_i) begin
      if (push) id_fifo[wr_ptr] <= sel;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == FW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky flag for a response arriving with nothing outstanding
   always_ff @(posedge clk_i) begin
      if (rst_i)          resp_err_o <= 1'b0;
      else if (empty_rsp) resp_err_o <= 1'b1;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based transaction model.
module tb_mem_port_arbiter;

   localparam int NP = 3;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int MO = 4;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   logic [NP-1:0]          p_req, p_we;
   logic [NP-1:0][AW-1:0]  p_addr;
   logic [NP-1:0][BW-1:0]  p_be;
   logic [NP-1:0][DW-1:0]  p_wdata;
   logic [NP-1:0]          gnt, rvalid;
   logic [DW-1:0]          rdata;
   logic                   m_req, m_we, m_gnt, m_rvalid, err;
   logic [AW-1:0]          m_addr;
   logic [BW-1:0]          m_be;
   logic [DW-1:0]          m_wdata, m_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .port_req_i(p_req), .port_addr_i(p_addr), .port_we_i(p_we),
      .port_be_i(p_be), .port_wdata_i(p_wdata),
      .port_gnt_o(gnt), .port_rvalid_o(rvalid), .port_rdata_o(rdata),
      .mem_req_o(m_req), .mem_addr_o(m_addr), .mem_we_o(m_we),
      .mem_be_o(m_be), .mem_wdata_o(m_wdata),
      .mem_gnt_i(m_gnt), .mem_rvalid_i(m_rvalid), .mem_rdata_i(m_rdata),
      .resp_err_o(err)
   );

   // reference model state
   int rr   = 0;
   bit lk   = 1'b0;
   int lidx = 0;
   int idq[$];
   bit e_err = 1'b0;

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // compare against the model at negedge, advance model, return after posedge
   task automatic cycle();
      int sel;
      bit any, e_req, xfer;
      logic [NP-1:0] e_gnt, e_rv;
      @(negedge clk);
      any = 1'b0;
      sel = 0;
      if (lk) begin
         sel = lidx;
         any = 1'b1;
      end else begin
         for (int i = 0; i < NP; i++) begin
            int c;
            c = (rr + i) % NP;
            if (!any && p_req[c]) begin
               any = 1'b1;
               sel = c;
            end
         end
      end
      e_req = !rst && any && p_req[sel] && (idq.size() < MO);
      e_gnt = (e_req && m_gnt) ? NP'(1 << sel) : '0;
      e_rv  = (!rst && m_rvalid && idq.size() > 0) ? NP'(1 << idq[0]) : '0;
      chk("mem_req",   m_req,   e_req);
      chk("mem_addr",  m_addr,  e_req ? p_addr[sel]  : '0);
      chk("mem_we",    m_we,    e_req ? p_we[sel]    : 1'b0);
      chk("mem_be",    m_be,    e_req ? p_be[sel]    : '0);
      chk("mem_wdata", m_wdata, e_req ? p_wdata[sel] : '0);
      chk("port_gnt",  gnt,     e_gnt);
      chk("port_rv",   rvalid,  e_rv);
      chk("rdata",     rdata,   m_rdata);
      chk("resp_err",  err,     e_err);
      if (rst) begin
         rr = 0;
         lk = 1'b0;
         idq.delete();
         e_err = 1'b0;
      end else begin
         xfer = e_req && m_gnt;
         if (m_rvalid && idq.size() == 0) e_err = 1'b1;
         if (e_rv != '0) void'(idq.pop_front());
         if (xfer) begin
            idq.push_back(sel);
            rr = (sel + 1) % NP;
         end
         if (!lk && e_req && !m_gnt) begin
            lk   = 1'b1;
            lidx = sel;
         end else if (lk && m_gnt) begin
            lk = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ports();
      for (int k = 0; k < NP; k++) begin
         p_addr[k]  = AW'($urandom);
         p_be[k]    = BW'($urandom);
         p_wdata[k] = $urandom;
         p_we[k]    = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p_req = '0;
      m_gnt = 1'b0;
      m_rvalid = 1'b0;
      #1;
      chk("rst_req", m_req, 1'b0);
      chk("rst_gnt", gnt, '0);
      cycle();
      rst = 1'b0;
   endtask

   logic [NP-1:0] ord_exp  [3];
   logic [DW-1:0] ord_data [3];

   initial begin
      rst = 1'b1;
      p_req = '0; p_we = '0; p_addr = '0; p_be = '0; p_wdata = '0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      ord_exp[0] = 3'b100; ord_exp[1] = 3'b001; ord_exp[2] = 3'b010;
      ord_data[0] = 32'hA; ord_data[1] = 32'hB; ord_data[2] = 32'hC;
      @(posedge clk);
      #1;

      // two ports requesting continuously: grants and responses alternate
      do_reset();
      p_req = 3'b011;
      m_gnt = 1'b1;
      for (int j = 0; j < 8; j++) begin
         m_rvalid = (j > 0);
         rand_ports();
         #1;
         chk("alt_gnt", gnt, (j % 2) ? 3'b010 : 3'b001);
         if (j > 0) chk("alt_rv", rvalid, (j % 2) ? 3'b001 : 3'b010);
         cycle();
      end
      m_rvalid = 1'b1;
      p_req = '0;
      cycle();
      m_rvalid = 1'b0;

      // stalled request stays locked on port 1 despite port 0 joining
      do_reset();
      rand_ports();
      for (int j = 0; j < 4; j++) begin
         p_req = (j >= 1) ? 3'b011 : 3'b010;
         m_gnt = (j == 3);
         #1;
         chk("lock_addr", m_addr, p_addr[1]);
         if (j == 3) chk("lock_gnt", gnt, 3'b010);
         cycle();
      end
      #1;
      chk("after_lock", gnt, 3'b001);
      cycle();

      // fill to MAX_OUTSTANDING, then a pop must not bypass the full check
      do_reset();
      p_req = 3'b111;
      m_gnt = 1'b1;
      for (int j = 0; j < MO; j++) begin
         #1;
         chk("fill_req", m_req, 1'b1);
         cycle();
      end
      #1;
      chk("full_req", m_req, 1'b0);
      cycle();
      m_rvalid = 1'b1;
      #1;
      chk("full_pop_req", m_req, 1'b0);
      chk("full_pop_rv", rvalid, 3'b001);
      cycle();
      m_rvalid = 1'b0;
      #1;
      chk("refill_req", m_req, 1'b1);
      cycle();

      // in-order response routing for grants 2,0,1
      do_reset();
      m_gnt = 1'b1;
      p_req = 3'b100; cycle();
      p_req = 3'b001; cycle();
      p_req = 3'b010; cycle();
      p_req = '0;
      for (int k = 0; k < 3; k++) begin
         m_rvalid = 1'b1;
         m_rdata  = ord_data[k];
         #1;
         chk("ord_rv", rvalid, ord_exp[k]);
         chk("ord_rdata", rdata, ord_data[k]);
         cycle();
      end
      m_rvalid = 1'b0;
      cycle();

      // spurious response with nothing outstanding
      do_reset();
      m_rvalid = 1'b1;
      #1;
      chk("spur_rv", rvalid, '0);
      cycle();
      m_rvalid = 1'b0;
      #1;
      chk("spur_err", err, 1'b1);
      cycle(); cycle(); cycle();
      chk("err_sticky", err, 1'b1);
      do_reset();
      chk("err_clr", err, 1'b0);

      // reset with two transfers outstanding drops them and rr_ptr
      do_reset();
      p_req = 3'b011;
      m_gnt = 1'b1;
      cycle(); cycle();
      p_req = '0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      m_rvalid = 1'b1;
      #1;
      chk("rst_rv", rvalid, '0);
      cycle();
      m_rvalid = 1'b0;
      #1;
      chk("rst_err", err, 1'b1);
      p_req = 3'b111;
      #1;
      chk("rst_rr", gnt, 3'b001);
      cycle();

      // random traffic
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         rst      = ($urandom_range(0, 59) == 0);
         p_req    = NP'($urandom);
         rand_ports();
         m_gnt    = ($urandom_range(0, 3) != 0);
         m_rvalid = (idq.size() > 0) ? 1'($urandom) : ($urandom_range(0, 29) == 0);
         m_rdata  = $urandom;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting ports (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width per port.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, in-flight transaction limit (legal 1..16).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 port_req_i  in  NUM_PORTS  per-port request.
REQ-009 port_addr_i  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port k at slice k.
REQ-010 port_we_i  in  NUM_PORTS  per-port write enable.
REQ-011 port_be_i  in  NUM_PORTS*DATA_WIDTH/8  packed byte enables.
REQ-012 port_wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data.
REQ-013 port_gnt_o  out  NUM_PORTS  per-port grant; at most one bit high.
REQ-014 port_rvalid_o  out  NUM_PORTS  per-port response valid; at most one bit high.
REQ-015 port_rdata_o  out  DATA_WIDTH  read data, shared by all ports.
REQ-016 mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  downstream request.
REQ-017 mem_gnt_i, mem_rvalid_i  in  1  downstream grant, response valid; mem_rdata_i  in  DATA_WIDTH  read data.
REQ-018 resp_err_o  out  1  sticky flag: mem_rvalid_i seen with no transaction outstanding.

Function
REQ-019 Handshake: transfer occurs in a cycle with req and gnt both high; responses return in order, one rvalid per transfer, reads and writes alike.
REQ-020 Arbitration: round-robin; pointer rr_ptr reset to 0; search order rr_ptr, rr_ptr+1, ... mod NUM_PORTS; first requesting port is selected.
REQ-021 After a transfer to port k, rr_ptr SHALL become (k+1) mod NUM_PORTS on the next edge; otherwise unchanged.
REQ-022 Lock: two states, IDLE and LOCKED; in IDLE, selection is combinational per REQ-020; if mem_req_o high and mem_gnt_i low, go to LOCKED and store selected index.
REQ-023 In LOCKED, the stored port SHALL be driven downstream regardless of other requests; return to IDLE on the cycle mem_gnt_i is high.
REQ-024 Mux: mem_addr_o/we/be/wdata SHALL equal the selected port's slices; zero when mem_req_o low.
REQ-025 mem_req_o = selected port's req AND count < MAX_OUTSTANDING AND NOT rst_i; gnt pass-through: port_gnt_o[sel] = mem_req_o AND mem_gnt_i, zero latency.
REQ-026 Outstanding tracking: ID FIFO, depth MAX_OUTSTANDING, width clog2(NUM_PORTS); push selected index on transfer; pop on mem_rvalid_i.
REQ-027 count SHALL increment on push only, decrement on pop only, hold on simultaneous push and pop.
REQ-028 Full: when count == MAX_OUTSTANDING, mem_req_o SHALL be 0 even if a pop occurs that cycle (no same-cycle bypass).
REQ-029 Response routing: port_rvalid_o[head] = mem_rvalid_i when count > 0, zero latency; port_rdata_o = mem_rdata_i always.
REQ-030 Empty: mem_rvalid_i with count == 0 SHALL assert no port_rvalid_o, not change count, and set resp_err_o from next cycle until reset.
REQ-031 FIFO read/write pointers SHALL wrap modulo MAX_OUTSTANDING.

Reset
REQ-032 While rst_i high: mem_req_o 0, port_gnt_o 0, port_rvalid_o 0; on next edge rr_ptr 0, state IDLE, count 0, FIFO pointers 0, resp_err_o 0.
REQ-033 Reset mid-operation SHALL discard all outstanding IDs; responses arriving after reset are treated per REQ-030.

Verification
REQ-034 NUM_PORTS=2; ports 0 and 1 request continuously, mem_gnt_i=1, rvalid 1 cycle later -> grants alternate 0,1,0,1; rvalids alternate in the same order.
REQ-035 Port 1 requests, mem_gnt_i=0 for 3 cycles, port 0 requests from cycle 2 -> mem_addr_o stays port 1's for all 4 cycles; port 1 granted cycle 4; port 0 next.
REQ-036 MAX_OUTSTANDING=4, mem_gnt_i=1, no rvalid -> exactly 4 grants, then mem_req_o 0; one mem_rvalid_i -> port_rvalid_o to first grantee, mem_req_o high the cycle after.
REQ-037 NUM_PORTS=3, ports 2,0,1 granted in that order, responses 0xA,0xB,0xC -> port_rvalid_o one-hot 2,0,1 with port_rdata_o 0xA,0xB,0xC.
REQ-038 After reset, mem_rvalid_i pulse with count 0 -> no port_rvalid_o; resp_err_o 1 next cycle, cleared only by rst_i.
REQ-039 Two transfers outstanding, rst_i for 1 cycle -> count 0, rr_ptr 0; subsequent rvalid sets resp_err_o.
